// File: rtl/rom_boot_loader.sv
// Boot sequencer: copies the instruction ROM into instruction RAM and holds the core in reset meanwhile.
// Optional BOOT_CHECKSUM_EN: last ROM word is a sum check over the copied words instead of image data.
module rom_boot_loader #(
  parameter int          WORDS      = 128,
  parameter logic [31:0] DST_BASE   = 32'h0000_0000,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [11:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        mem_wr_req,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  input  logic        mem_wr_ack,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, DONE, ERROR} state_t;

`ifdef BOOT_CHECKSUM_EN
  localparam logic [6:0] LAST_IDX  = 7'(WORDS - 2);
  localparam logic [6:0] CHECK_IDX = 7'(WORDS - 1);
`else
  localparam logic [6:0] LAST_IDX  = 7'(WORDS - 1);
`endif

  state_t      state, state_nxt;
  logic [6:0]  idx, idx_nxt;
  logic        auto_pend;
  logic [11:0] rom_addr_q;
  logic        capture;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] acc, acc_nxt;
`endif

  // rom_addr follows idx only while fetching, otherwise holds the last fetched address
  assign rom_addr = (state == FETCH) ? {3'b000, idx, 2'b00} : rom_addr_q;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    acc_nxt   = acc;
`endif
    case (state)
      IDLE: begin
        if (auto_pend || start) begin
          state_nxt = FETCH;
          idx_nxt   = '0;
`ifdef BOOT_CHECKSUM_EN
          acc_nxt   = '0;
`endif
        end
      end
      FETCH: begin
`ifdef BOOT_CHECKSUM_EN
        if (idx == CHECK_IDX) begin
          state_nxt = (rom_inst == acc) ? DONE : ERROR;
        end else begin
          acc_nxt   = acc + rom_inst;
          capture   = 1'b1;
          state_nxt = WRITE;
        end
`else
        capture   = 1'b1;
        state_nxt = WRITE;
`endif
      end
      WRITE: begin
        if (mem_wr_ack) begin
          if (idx == LAST_IDX) begin
`ifdef BOOT_CHECKSUM_EN
            idx_nxt   = idx + 7'd1;
            state_nxt = FETCH;
`else
            state_nxt = DONE;
`endif
          end else begin
            idx_nxt   = idx + 7'd1;
            state_nxt = FETCH;
          end
        end
      end
      DONE, ERROR: begin
        if (start) begin
          state_nxt = FETCH;
          idx_nxt   = '0;
`ifdef BOOT_CHECKSUM_EN
          acc_nxt   = '0;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      auto_pend   <= AUTO_START;
      rom_addr_q  <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_wr_req  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      core_hold   <= 1'b1;
      err         <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      acc         <= '0;
`endif
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      auto_pend   <= 1'b0;
      rom_addr_q  <= rom_addr;
      if (capture) begin
        mem_wr_addr <= DST_BASE + {23'b0, idx, 2'b00};
        mem_wr_data <= rom_inst;
      end
      // status flags are registered from the next state so they carry no input-to-output path
      mem_wr_req  <= (state_nxt == WRITE);
      busy        <= (state_nxt == FETCH) || (state_nxt == WRITE);
      done        <= (state_nxt == DONE);
      core_hold   <= (state_nxt != DONE);
`ifdef BOOT_CHECKSUM_EN
      err         <= (state_nxt == ERROR);
      acc         <= acc_nxt;
`else
      err         <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Directed bench for rom_boot_loader: vector table for the nominal copy, hand sequences for corner cases.
module tb_rom_boot_loader;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // DUT A: WORDS=4, AUTO_START=1, DST_BASE=0
  logic        reset_a, start_a, ack_a;
  logic [11:0] rom_addr_a;
  logic [31:0] rom_inst_a, wr_addr_a, wr_data_a;
  logic        req_a, hold_a, busy_a, done_a, err_a;
  logic [31:0] rom_a [4];
  assign rom_inst_a = rom_a[rom_addr_a[3:2]];

  // DUT B: WORDS=4, AUTO_START=0, DST_BASE=0x1000
  logic        reset_b, start_b, ack_b;
  logic [11:0] rom_addr_b;
  logic [31:0] rom_inst_b, wr_addr_b, wr_data_b;
  logic        req_b, hold_b, busy_b, done_b, err_b;
  logic [31:0] rom_b [4];
  assign rom_inst_b = rom_b[rom_addr_b[3:2]];

  rom_boot_loader #(.WORDS(4), .DST_BASE(32'h0000_0000), .AUTO_START(1'b1)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a),
    .rom_addr(rom_addr_a), .rom_inst(rom_inst_a),
    .mem_wr_req(req_a), .mem_wr_addr(wr_addr_a), .mem_wr_data(wr_data_a), .mem_wr_ack(ack_a),
    .core_hold(hold_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  rom_boot_loader #(.WORDS(4), .DST_BASE(32'h0000_1000), .AUTO_START(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b),
    .rom_addr(rom_addr_b), .rom_inst(rom_inst_b),
    .mem_wr_req(req_b), .mem_wr_addr(wr_addr_b), .mem_wr_data(wr_data_b), .mem_wr_ack(ack_b),
    .core_hold(hold_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] data;
    logic [11:0] raddr;
    logic        busy;
    logic        done;
    logic        hold;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_a(input string name, input vec_t e);
    check(name, {req_a, wr_addr_a, wr_data_a, rom_addr_a, busy_a, done_a, hold_a, err_a},
          {e.req, e.addr, e.data, e.raddr, e.busy, e.done, e.hold, 1'b0});
  endtask

  // leaves the bench at the falling edge of cycle 0 after release
  task automatic reset_dut_a();
    reset_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_dut_b();
    reset_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      check_a($sformatf("%s_cyc%0d", tag, i), tbl[i]);
    end
  endtask

  int writes;

  initial begin
    reset_a = 1'b1; start_a = 1'b0; ack_a = 1'b1;
    reset_b = 1'b1; start_b = 1'b0; ack_b = 1'b1;
    rom_a[0] = 32'h11; rom_a[1] = 32'h22; rom_a[2] = 32'h33; rom_a[3] = 32'h44;
    for (int k = 0; k < 4; k++) rom_b[k] = 32'hCAFE_0000 + 32'(k);

    //          req addr      data      raddr   busy done hold
    tbl[0]  = '{1'b0, 32'h0, 32'h00, 12'h0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 32'h0, 32'h00, 12'h0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 32'h0, 32'h11, 12'h0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 32'h0, 32'h11, 12'h4, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 32'h4, 32'h22, 12'h4, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 32'h4, 32'h22, 12'h8, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 32'h8, 32'h33, 12'h8, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 32'h8, 32'h33, 12'hC, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 32'hC, 32'h44, 12'hC, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 32'hC, 32'h44, 12'hC, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 32'hC, 32'h44, 12'hC, 1'b0, 1'b1, 1'b0};

`ifndef BOOT_CHECKSUM_EN
    // nominal copy, ack tied high
    reset_dut_a();
    run_table("nominal");

    // ack withheld for three cycles on word 1
    ack_a = 1'b1;
    reset_dut_a();
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) @(negedge clk);
      ack_a = !(c >= 4 && c <= 6);
      if (c >= 4 && c <= 7)
        check($sformatf("ackwait_stable_c%0d", c), {req_a, wr_addr_a, wr_data_a}, {1'b1, 32'h4, 32'h22});
      if (c == 11) check("ackwait_done_c11", done_a, 1'b0);
      if (c == 12) check("ackwait_done_c12", {done_a, hold_a}, {1'b1, 1'b0});
    end
    ack_a = 1'b1;

    // reset during word 2 WRITE
    reset_dut_a();
    repeat (6) @(negedge clk);
    check("midreset_before", {req_a, wr_addr_a, wr_data_a}, {1'b1, 32'h8, 32'h33});
    #1 reset_a = 1'b1;
    #1 check_a("midreset_async", tbl[0]);
    @(posedge clk);
    #1 reset_a = 1'b0;
    @(negedge clk);
    run_table("restart");

    // AUTO_START=0 instance, DST_BASE=0x1000
    reset_dut_b();
    writes = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (req_b || busy_b) writes++;
    end
    check("noauto_idle", {32'(writes), rom_addr_b, hold_b, done_b}, {32'd0, 12'h0, 1'b1, 1'b0});
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    check("start_fetch", {busy_b, req_b, rom_addr_b, hold_b}, {1'b1, 1'b0, 12'h0, 1'b1});
    @(negedge clk);
    check("base_word0", {req_b, wr_addr_b, wr_data_b}, {1'b1, 32'h1000, 32'hCAFE_0000});
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    check("busy_start_ignored", {req_b, wr_addr_b, wr_data_b}, {1'b1, 32'h1004, 32'hCAFE_0001});
    repeat (4) @(negedge clk);
    check("b_last_write", {req_b, wr_addr_b, done_b}, {1'b1, 32'h100C, 1'b0});
    @(negedge clk);
    check("b_done", {done_b, hold_b, busy_b, err_b}, {1'b1, 1'b0, 1'b0, 1'b0});
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    check("restart_from_done", {busy_b, done_b, hold_b, req_b, rom_addr_b}, {1'b1, 1'b0, 1'b1, 1'b0, 12'h0});
    @(negedge clk);
    check("restart_word0", {req_b, wr_addr_b, wr_data_b}, {1'b1, 32'h1000, 32'hCAFE_0000});
`else
    // checksum: 1+2+3 = 6 matches
    rom_a[0] = 32'h1; rom_a[1] = 32'h2; rom_a[2] = 32'h3; rom_a[3] = 32'h6;
    reset_dut_a();
    writes = 0;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) @(negedge clk);
      if (req_a && ack_a) writes++;
      if (c == 7) check("cs_done_c7", done_a, 1'b0);
      if (c == 8) check("cs_done_c8", {done_a, hold_a, err_a}, {1'b1, 1'b0, 1'b0});
    end
    check("cs_write_count", 32'(writes), 32'd3);

    // checksum mismatch
    rom_a[3] = 32'h7;
    reset_dut_a();
    repeat (8) @(negedge clk);
    check("cs_err_c8", {err_a, hold_a, done_a}, {1'b1, 1'b1, 1'b0});
    repeat (4) @(negedge clk);
    check("cs_err_holds", {err_a, hold_a, done_a}, {1'b1, 1'b1, 1'b0});
    rom_a[3] = 32'h6;
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("cs_retry", {err_a, busy_a, hold_a, rom_addr_a}, {1'b0, 1'b1, 1'b1, 12'h0});
    repeat (7) @(negedge clk);
    check("cs_retry_done", {done_a, err_a}, {1'b1, 1'b0});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rom_boot_loader.md
# rom_boot_loader

Boot sequencer for the SoC instruction ROM. After reset it walks the 128-word instruction ROM, copies each word into the instruction RAM through a valid/ack write port, and holds the core in reset until the image is in place. It sits between the ROM, the instruction-memory write port and the core reset input, and is the only master of the ROM address bus while the core is held.

## Interface
- WORDS, 128: number of 32-bit ROM words to process; 2..128.
- DST_BASE, 32'h0000_0000: byte address in instruction RAM for word 0.
- AUTO_START, 1: 1 starts a copy automatically on the first cycle after reset deasserts; 0 waits for `start`.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a copy from IDLE, DONE or ERROR.
- rom_addr  out  12  byte address to the ROM; always word-aligned, bits [1:0] = 0.
- rom_inst  in  32  combinational ROM read data for `rom_addr`.
- mem_wr_req  out  1  write request to instruction RAM.
- mem_wr_addr  out  32  write byte address, DST_BASE + 4*idx.
- mem_wr_data  out  32  write data.
- mem_wr_ack  in  1  write accepted in the cycle it is high while `mem_wr_req` = 1.
- core_hold  out  1  keeps the core in reset while high.
- busy  out  1  copy in progress (FETCH or WRITE).
- done  out  1  image loaded; core released.
- err  out  1  checksum mismatch; see Configuration.

## Operation
- States: IDLE, FETCH, WRITE, DONE, ERROR. Word index `idx` is 7 bits and counts 0..WORDS-1.
- Reset values: state IDLE, idx 0, rom_addr 0, mem_wr_req 0, mem_wr_addr 0, mem_wr_data 0, core_hold 1, busy 0, done 0, err 0, checksum accumulator 0.
- IDLE: goes to FETCH when AUTO_START = 1 (first cycle only, after reset) or when `start` = 1. Clears idx and the accumulator on exit.
- FETCH, one cycle: rom_addr = idx<<2. At the end of the cycle, rom_inst is captured into mem_wr_data and mem_wr_addr = DST_BASE + (idx<<2) is loaded. Go to WRITE.
- WRITE: mem_wr_req = 1. Address and data stay stable until ack.
  - On mem_wr_ack: if idx = last copied index, go to DONE (or to the check, see Configuration); otherwise increment idx and go to FETCH.
  - mem_wr_req drops in the cycle after ack.
- DONE: core_hold = 0, done = 1. Holds until `start` or reset.
- ERROR: core_hold = 1, err = 1, done = 0. Holds until `start` or reset.
- `start` while busy is ignored. `start` in DONE or ERROR clears done and err, reasserts core_hold in the next cycle, and begins a new copy from idx 0.
- Reset mid-copy aborts immediately: all outputs go to reset values and the partial image is abandoned. The next copy behaves per AUTO_START.
- rom_addr is held at its last value outside FETCH.

## Timing
- With mem_wr_ack tied high, each word takes 2 cycles: FETCH, then WRITE.
- With AUTO_START = 1, cycle 0 after reset deasserts is IDLE, word k's WRITE occurs at cycle 2k+2, and DONE is entered (done = 1, core_hold = 0) at cycle 2*WORDS+1.
- Each ack wait adds one cycle per cycle of ack delay. mem_wr_req is never deasserted without an ack.
- done, err, core_hold and busy are registered outputs with no combinational path from the inputs.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - Words 0..WORDS-2 are copied and summed modulo 2^32.
  - Word WORDS-1 is fetched but not written; it is compared against the sum in a single FETCH cycle.
  - Match: go to DONE. Mismatch: go to ERROR.
  - DONE time is 2*WORDS cycles after reset with ack tied high.
- BOOT_CHECKSUM_EN undefined: all WORDS words are copied, ERROR is unreachable, and err is constant 0.

## Test plan
- WORDS = 4, AUTO_START = 1, ack tied high, ROM = 11,22,33,44 (hex) -> writes (0,11),(4,22),(8,33),(C,44); done = 1 and core_hold = 0 at cycle 9.
- Ack delayed 3 cycles on word 1 -> mem_wr_addr/data stable at 4/22 across the wait; done is 3 cycles later than the no-wait case.
- Reset asserted during word 2's WRITE -> outputs return to reset values on the same edge; the copy restarts from address 0 after release.
- AUTO_START = 0 -> no writes for 20 cycles; `start` pulse -> copy begins the next cycle. `start` during busy has no effect.
- BOOT_CHECKSUM_EN, ROM = 1,2,3,6 -> 3 writes, then done. ROM = 1,2,3,7 -> err = 1, core_hold stays 1, then `start` clears err and retries.
- DST_BASE = 32'h1000 -> first mem_wr_addr is 32'h1000 and rom_addr starts at 0.
